muldiv_ctrl: RTL and testbench

Iterative multiply/divide controller for the execute stage of the 5-stage pipeline. Accepts MULT/MULTU/DIV/DIVU from E with forwarded operands, runs a shift-add multiply or restoring divide over N cycles, and owns the HI/LO registers. Serves MFHI/MFLO/MTHI/MTLO from E. Raises a stall request to the hazard unit while a HI/LO access would conflict with a running operation.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/md_step_core.sv | 34 +++
 rtl/muldiv_ctrl.sv | 130 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide controller.
// Optional multiply early-out is selected with MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int N = 32;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_HI   = 2'b01;
  localparam logic [1:0] MF_LO   = 2'b10;
  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_HI   = 2'b01;
  localparam logic [1:0] MT_LO   = 2'b10;

  // Index of the highest set bit, 0 for a zero input.
  function automatic logic [CNT_W-1:0] msb_idx(input logic [N-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) msb_idx = CNT_W'(i);
  endfunction

endpackage

// File: rtl/md_step_core.sv
// One iteration of shift-add multiply (LSB first) or restoring divide on
// unsigned magnitudes; purely combinational.
module md_step_core
  import muldiv_pkg::*;
(
  input  logic         div_mode,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] q,
  input  logic [N-1:0] operand,
  output logic [N-1:0] acc_nxt,
  output logic [N-1:0] q_nxt
);

  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         ge;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, operand} : {(N+1){1'b0}});
    shifted = {acc, q[N-1]};
    ge      = shifted >= {1'b0, operand};
    // when ge holds the true difference is below 2^N, so N bits suffice
    diff    = shifted[N-1:0] - operand;
    if (div_mode) begin
      acc_nxt = ge ? diff : shifted[N-1:0];
      q_nxt   = {q[N-2:0], ge};
    end else begin
      acc_nxt = sum[N:1];
      q_nxt   = {sum[0], q[N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO for the E stage.
// Define MULDIV_EARLY_OUT_EN to end multiplies after the top multiplier bit.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start_E,
  input  logic [1:0]   op_E,
  input  logic [N-1:0] srcA_E,
  input  logic [N-1:0] srcB_E,
  input  logic [1:0]   mf_E,
  input  logic [1:0]   mt_E,
  input  logic         flush_E,
  output logic         busy,
  output logic         stall_md,
  output logic [N-1:0] hilo_out_E,
  output logic         div_by_zero
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, last, mul_last;
  logic [N-1:0]     acc, q, dvs, acc_nxt, q_nxt;
  logic [N-1:0]     hi, lo, hi_res, lo_res, a_mag, b_mag, quot, rem;
  logic [2*N-1:0]   prod, prod_s;
  op_e              op_r;
  logic             neg_res, neg_a, is_div_r, accept, a_neg, b_neg;

  assign is_div_r = (op_r == DIV) || (op_r == DIVU);
  assign accept   = (state == IDLE) & start_E & ~flush_E;
  assign a_neg    = ~op_E[0] & srcA_E[N-1];
  assign b_neg    = ~op_E[0] & srcB_E[N-1];
  assign a_mag    = a_neg ? -srcA_E : srcA_E;
  assign b_mag    = b_neg ? -srcB_E : srcB_E;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = msb_idx(b_mag);
`else
  assign mul_last = CNT_LAST;
`endif

  md_step_core u_step (
    .div_mode (is_div_r),
    .acc      (acc),
    .q        (q),
    .operand  (dvs),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    prod = {acc, q};
`ifdef MULDIV_EARLY_OUT_EN
    // an early stop leaves the product shifted left by the skipped steps
    prod = prod >> (CNT_LAST - cnt);
`endif
    prod_s = neg_res ? -prod : prod;
    quot   = neg_res ? -q : q;
    rem    = neg_a ? -acc : acc;
    if (is_div_r) begin
      hi_res = rem;
      lo_res = (dvs == '0) ? '1 : quot;
    end else begin
      hi_res = prod_s[2*N-1:N];
      lo_res = prod_s[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= '0;
      acc     <= '0;
      q       <= '0;
      dvs     <= '0;
      op_r    <= MULT;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            acc     <= '0;
            q       <= op_E[1] ? a_mag : b_mag;
            dvs     <= op_E[1] ? b_mag : a_mag;
            op_r    <= op_e'(op_E);
            neg_res <= a_neg ^ b_neg;
            neg_a   <= a_neg;
            last    <= op_E[1] ? CNT_LAST : mul_last;
          end else if (~flush_E & ~start_E) begin
            if (mt_E == MT_HI) hi <= srcA_E;
            if (mt_E == MT_LO) lo <= srcA_E;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          if (cnt != last) cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign stall_md    = busy & (start_E | (mf_E != MF_NONE) | (mt_E != MT_NONE)) & ~flush_E;
  assign div_by_zero = (state == FIX) & is_div_r & (dvs == '0);
  assign hilo_out_E  = (mf_E == MF_HI) ? hi : (mf_E == MF_LO) ? lo : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with an arithmetic reference model checked
// every cycle; honours MULDIV_EARLY_OUT_EN for multiply latency.
module tb_muldiv_ctrl;

  localparam int N = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_B2 = 3;   // multiplier magnitude 2 -> k = 2
  localparam int LAT_B4 = 4;   // multiplier magnitude 4 -> k = 3
`else
  localparam int LAT_B2 = 33;
  localparam int LAT_B4 = 33;
`endif

  logic          clk = 1'b0;
  logic          reset, start_E, flush_E;
  logic [1:0]    op_E, mf_E, mt_E;
  logic [N-1:0]  srcA_E, srcB_E;
  logic          busy, stall_md, div_by_zero;
  logic [N-1:0]  hilo_out_E;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  muldiv_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_E     (start_E),
    .op_E        (op_E),
    .srcA_E      (srcA_E),
    .srcB_E      (srcB_E),
    .mf_E        (mf_E),
    .mt_E        (mt_E),
    .flush_E     (flush_E),
    .busy        (busy),
    .stall_md    (stall_md),
    .hilo_out_E  (hilo_out_E),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] m_hi = '0, m_lo = '0;
  logic [64:0]  p_res = '0;   // {div_by_zero, hi, lo}
  int           m_left = 0;   // busy cycles still to come

  function automatic logic [64:0] compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    logic [31:0] hi, lo;
    logic dz;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        up = sp;
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 0;
          lo = 32'h8000_0000;
        end else if (op == 2'b10) begin
          lo = int'(a) / int'(b);
          hi = int'(a) % int'(b);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
    return {dz, hi, lo};
  endfunction

  function automatic int run_len(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      logic [31:0] mag;
      int k;
      mag = (op == 2'b00 && b[31]) ? -b : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
      return k;
    end
`endif
    return (op[1] || !op[1]) ? N : N;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
      end
    end else if (start_E && !flush_E) begin
      p_res  <= compute(op_E, srcA_E, srcB_E);
      m_left <= run_len(op_E, srcB_E) + 1;
    end else if (mt_E != 2'b00 && !flush_E) begin
      if (mt_E == 2'b01) m_hi <= srcA_E;
      if (mt_E == 2'b10) m_lo <= srcA_E;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_left == 1 && p_res[64]));
      chk("stall_md", 32'(stall_md),
          32'((m_left > 0) && (start_E || mf_E != 0 || mt_E != 0) && !flush_E));
      chk("hilo_out_E", hilo_out_E, (mf_E == 2'b01) ? m_hi : (mf_E == 2'b10) ? m_lo : 32'h0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_E = 1'b1;
    op_E    = op;
    srcA_E  = a;
    srcB_E  = b;
    @(posedge clk) #1;
    start_E = 1'b0;
  endtask

  task automatic wait_idle(output int nbusy, output int ndbz);
    bit done;
    nbusy = 0;
    ndbz  = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else begin
        nbusy++;
        if (div_by_zero) ndbz++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after 200 cycles, required 0");
    end
    @(posedge clk) #1;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mf_E = 2'b01;
    #1 chk({name, " hi"}, hilo_out_E, exp_hi);
    mf_E = 2'b10;
    #1 chk({name, " lo"}, hilo_out_E, exp_lo);
    mf_E = 2'b00;
  endtask

  int nb, nd, nst;
  bit done;

  initial begin
    reset = 1'b1; start_E = 1'b0; flush_E = 1'b0;
    op_E = 2'b00; mf_E = 2'b00; mt_E = 2'b00; srcA_E = '0; srcB_E = '0;
    @(posedge clk) #1;
    checking = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;

    mf_E = 2'b01;
    #1 chk("reset stall", 32'(stall_md), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    mf_E = 2'b00;
    read_hilo("reset", 32'h0, 32'h0);

    issue(2'b00, 32'hFFFF_FFFF, 32'd2);
    wait_idle(nb, nd);
    chk("mult busy cycles", nb, LAT_B2);
    read_hilo("mult -1*2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_idle(nb, nd);
    chk("multu busy cycles", nb, LAT_B2);
    read_hilo("multu", 32'h1, 32'hFFFF_FFFE);

    issue(2'b10, -32'd7, 32'd2);
    wait_idle(nb, nd);
    chk("div busy cycles", nb, 33);
    read_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(2'b11, 32'd7, 32'd2);
    wait_idle(nb, nd);
    read_hilo("divu 7/2", 32'h1, 32'h3);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb, nd);
    chk("minint/-1 flag", nd, 0);
    read_hilo("minint/-1", 32'h0, 32'h8000_0000);

    issue(2'b11, 32'd5, 32'd0);
    wait_idle(nb, nd);
    chk("dbz pulse cycles", nd, 1);
    read_hilo("divu 5/0", 32'h5, 32'hFFFF_FFFF);

    // mflo held from the cycle after the first RUN cycle
    issue(2'b11, 32'd100, 32'd7);
    @(posedge clk) #1;
    mf_E = 2'b10;
    nst = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!stall_md) done = 1'b1;
      else nst++;
    end
    chk("mflo stall cycles", nst, 32);
    chk("mflo after stall", hilo_out_E, 32'd14);
    chk("busy after stall", 32'(busy), 32'd0);
    @(posedge clk) #1;
    mf_E = 2'b00;
    read_hilo("divu 100/7", 32'd2, 32'd14);

    mt_E = 2'b01; srcA_E = 32'h1234;
    @(posedge clk) #1;
    mt_E = 2'b10; srcA_E = 32'h5678;
    @(posedge clk) #1;
    mt_E = 2'b01; srcA_E = 32'hDEAD; flush_E = 1'b1;
    @(posedge clk) #1;
    mt_E = 2'b00; flush_E = 1'b0;
    read_hilo("mthi/mtlo", 32'h1234, 32'h5678);

    start_E = 1'b1; flush_E = 1'b1; op_E = 2'b00; srcA_E = 32'd3; srcB_E = 32'd3;
    @(posedge clk) #1;
    start_E = 1'b0; flush_E = 1'b0;
    chk("flushed start busy", 32'(busy), 32'd0);
    read_hilo("after flush", 32'h1234, 32'h5678);

    // start and mtlo together: start wins, LO keeps its old value while busy
    mt_E = 2'b10;
    issue(2'b00, 32'd3, -32'd4);
    mt_E = 2'b00;
    mf_E = 2'b10;
    #1 chk("lo during run", hilo_out_E, 32'h5678);
    mf_E = 2'b00;
    wait_idle(nb, nd);
    chk("mult 3*-4 busy cycles", nb, LAT_B4);
    read_hilo("mult 3*-4", 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    chk("busy after reset", 32'(busy), 32'd0);
    read_hilo("after reset", 32'h0, 32'h0);

    issue(2'b01, 32'd3, 32'd2);
    wait_idle(nb, nd);
    chk("multu 3*2 busy cycles", nb, LAT_B2);
    read_hilo("multu 3*2", 32'h0, 32'h6);

    repeat (2) @(posedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
